wram_dma: RTL and testbench

- RV-side initiator that streams a full WRAM image over the rv_* toggle request port.
- Load direction: byte stream in, one WRAM write per byte. Save direction: one WRAM read per byte, byte stream out.
- Sits between the IOSys save/load logic and the SDRAM/WRAM arbiter's RV port. Drives o_wram_load_ongoing so the arbiter gives RV priority during loads.

---
 rtl/nes_mem_pkg.sv | 20 ++
 rtl/rv_req_toggle.sv | 67 ++++++
 rtl/wram_dma.sv | 192 +++++++++++++++++++
 tb/tb_wram_dma.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_mem_pkg.sv
// Shared NES memory-map constants, transfer direction codes and the WRAM DMA state type.
package nes_mem_pkg;

  localparam logic [22:0] WRAM_RV_BASE = 23'h66000;
  localparam int          WRAM_SIZE    = 8192;

  localparam logic DIR_SAVE = 1'b0;
  localparam logic DIR_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_CAPTURE,
    ST_PUSH,
    ST_DONE
  } dma_state_t;

endpackage

// File: rtl/rv_req_toggle.sv
// Toggle-handshake initiator for the arbiter RV port: owns rv_req, holds address/data
// stable while a request is outstanding, and strobes read-data-valid one cycle after ack.
module rv_req_toggle
  import nes_mem_pkg::*;
#(
  parameter logic [22:0] RST_ADDR = WRAM_RV_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_issue,
  input  logic [22:0] i_addr,
  input  logic        i_we,
  input  logic        i_din_load,
  input  logic [7:0]  i_din,
  input  logic        i_rv_req_ack,
  output logic [22:0] o_rv_addr,
  output logic        o_rv_we,
  output logic [15:0] o_rv_din,
  output logic        o_rv_req,
  output logic        o_idle,
  output logic        o_rd_valid
);

  logic        r_req;
  logic        r_we;
  logic        r_pend;
  logic        r_rd_valid;
  logic [22:0] r_addr;
  logic [15:0] r_din;
  logic        w_idle;

  assign w_idle = (r_req == i_rv_req_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_pend     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_addr     <= RST_ADDR;
      r_din      <= 16'h0000;
    end else begin
      r_rd_valid <= 1'b0;
      // a new toggle is only legal once the previous one has been acknowledged
      if (i_issue && w_idle) begin
        r_req  <= ~r_req;
        r_addr <= i_addr;
        r_we   <= i_we;
        r_pend <= 1'b1;
      end else if (r_pend && w_idle) begin
        r_pend     <= 1'b0;
        r_rd_valid <= ~r_we;
      end
      if (i_din_load) begin
        r_din <= {8'h00, i_din};
      end
    end
  end

  assign o_rv_addr  = r_addr;
  assign o_rv_we    = r_we;
  assign o_rv_din   = r_din;
  assign o_rv_req   = r_req;
  assign o_idle     = w_idle;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/wram_dma.sv
// WRAM image streamer on the RV toggle port: load (stream -> WRAM) or save (WRAM -> stream).
// Define WRAM_DMA_CHECKSUM_EN to add the 8-bit o_checksum output.
//
// state     | meaning
// IDLE      | waiting for i_start with the handshake idle
// FETCH     | load: waiting for a stream byte
// ISSUE     | toggle rv_req for byte at BASE_ADDR+count
// WAIT_ACK  | waiting for rv_req_ack to match
// CAPTURE   | save: read data valid on rv_dout this cycle
// PUSH      | save: holding o_m_data until i_m_ready
// DONE      | one-cycle o_done pulse
module wram_dma
  import nes_mem_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR = WRAM_RV_BASE,
  parameter int          LEN       = WRAM_SIZE,
  parameter int          CNT_W     = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_dir,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_wram_load_ongoing,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  output logic [7:0]  o_m_data,
  output logic        o_m_valid,
  input  logic        i_m_ready,
`ifdef WRAM_DMA_CHECKSUM_EN
  output logic [7:0]  o_checksum,
`endif
  output logic [22:0] rv_addr,
  output logic        rv_word,
  output logic [15:0] rv_din,
  output logic [1:0]  rv_ds,
  output logic        rv_we,
  output logic        rv_req,
  input  logic        rv_req_ack,
  input  logic [15:0] rv_dout
);

  dma_state_t       r_state;
  logic             r_dir;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_load_ongoing;
  logic             r_s_ready;
  logic             r_m_valid;
  logic [7:0]       r_m_data;
`ifdef WRAM_DMA_CHECKSUM_EN
  logic [7:0]       r_sum;
`endif

  logic        w_idle;
  logic        w_rd_valid;
  logic        w_last;
  logic        w_issue;
  logic        w_din_load;
  logic [22:0] w_addr;
  logic        w_unused_dout_hi;

  assign w_last     = (r_count == CNT_W'(LEN - 1));
  assign w_issue    = (r_state == ST_ISSUE);
  assign w_din_load = (r_state == ST_FETCH) && i_s_valid;
  assign w_addr     = BASE_ADDR + 23'(r_count);
  assign w_unused_dout_hi = ^rv_dout[15:8];

  rv_req_toggle #(
    .RST_ADDR(BASE_ADDR)
  ) u_req (
    .clk         (clk),
    .reset       (reset),
    .i_issue     (w_issue),
    .i_addr      (w_addr),
    .i_we        (r_dir),
    .i_din_load  (w_din_load),
    .i_din       (i_s_data),
    .i_rv_req_ack(rv_req_ack),
    .o_rv_addr   (rv_addr),
    .o_rv_we     (rv_we),
    .o_rv_din    (rv_din),
    .o_rv_req    (rv_req),
    .o_idle      (w_idle),
    .o_rd_valid  (w_rd_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_dir          <= DIR_SAVE;
      r_count        <= '0;
      r_done         <= 1'b0;
      r_load_ongoing <= 1'b0;
      r_s_ready      <= 1'b0;
      r_m_valid      <= 1'b0;
      r_m_data       <= 8'h00;
`ifdef WRAM_DMA_CHECKSUM_EN
      r_sum          <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && w_idle) begin
            r_dir   <= i_dir;
            r_count <= '0;
`ifdef WRAM_DMA_CHECKSUM_EN
            r_sum   <= 8'h00;
`endif
            if (i_dir == DIR_LOAD) begin
              r_state        <= ST_FETCH;
              r_s_ready      <= 1'b1;
              r_load_ongoing <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_FETCH: begin
          if (i_s_valid) begin
            r_s_ready <= 1'b0;
`ifdef WRAM_DMA_CHECKSUM_EN
            r_sum     <= r_sum + i_s_data;
`endif
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (w_idle) begin
            if (r_dir == DIR_LOAD) begin
              if (w_last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_count   <= r_count + CNT_W'(1);
                r_s_ready <= 1'b1;
                r_state   <= ST_FETCH;
              end
            end else begin
              r_state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (w_rd_valid) begin
            r_m_data  <= rv_dout[7:0];
            r_m_valid <= 1'b1;
`ifdef WRAM_DMA_CHECKSUM_EN
            r_sum     <= r_sum + rv_dout[7:0];
`endif
            r_state   <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (i_m_ready) begin
            r_m_valid <= 1'b0;
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count + CNT_W'(1);
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          r_load_ongoing <= 1'b0;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // busy also covers a handshake left unmatched after a lone reset
  assign o_busy              = (r_state != ST_IDLE) || !w_idle;
  assign o_done              = r_done;
  assign o_wram_load_ongoing = r_load_ongoing;
  assign o_s_ready           = r_s_ready;
  assign o_m_valid           = r_m_valid;
  assign o_m_data            = r_m_data;
  assign rv_word             = 1'b0;
  assign rv_ds               = 2'b01;
`ifdef WRAM_DMA_CHECKSUM_EN
  assign o_checksum          = r_sum;
`endif

endmodule

// File: tb/tb_wram_dma.sv
// Directed bench for wram_dma (LEN=4) with a toggle-handshake arbiter responder model.
module tb_wram_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_dir;
  logic        o_busy, o_done, o_wram_load_ongoing;
  logic [7:0]  i_s_data = 8'h00;
  logic        i_s_valid = 1'b0;
  logic        o_s_ready;
  logic [7:0]  o_m_data;
  logic        o_m_valid;
  logic        i_m_ready = 1'b1;
  logic [22:0] rv_addr;
  logic        rv_word;
  logic [15:0] rv_din;
  logic [1:0]  rv_ds;
  logic        rv_we, rv_req;
  logic        rv_req_ack;
  logic [15:0] rv_dout;
`ifdef WRAM_DMA_CHECKSUM_EN
  logic [7:0]  o_checksum;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wram_dma #(.LEN(4)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_dir(i_dir),
    .o_busy(o_busy), .o_done(o_done), .o_wram_load_ongoing(o_wram_load_ongoing),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
`ifdef WRAM_DMA_CHECKSUM_EN
    .o_checksum(o_checksum),
`endif
    .rv_addr(rv_addr), .rv_word(rv_word), .rv_din(rv_din), .rv_ds(rv_ds),
    .rv_we(rv_we), .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout)
  );

  // arbiter model: acks dly_cfg cycles after seeing a toggle, logs every request
  logic [7:0]  mem [0:15];
  logic [22:0] log_addr[$];
  logic        log_we[$];
  logic [15:0] log_din[$];
  int          dly_cfg = 1;
  int          dly_cnt = 0;
  int          ack_cnt = 0;
  int          hs_err = 0;
  logic        pend = 1'b0;
  logic [22:0] p_addr;
  logic        p_we, p_req;
  logic [15:0] p_din;

  always @(posedge clk) begin
    if (reset) begin
      rv_req_ack <= 1'b0;
      rv_dout    <= 16'h0000;
      pend = 1'b0;
      dly_cnt = 0;
    end else if (pend) begin
      if (rv_addr !== p_addr || rv_we !== p_we || rv_din !== p_din || rv_req !== p_req) hs_err++;
      if (dly_cnt == 0) begin
        rv_req_ack <= p_req;
        if (p_we) mem[p_addr[3:0]] = p_din[7:0];
        else rv_dout <= {8'hC3, mem[p_addr[3:0]]};
        pend = 1'b0;
        ack_cnt++;
      end else begin
        dly_cnt--;
      end
    end else if (rv_req !== rv_req_ack) begin
      pend = 1'b1;
      p_addr = rv_addr; p_we = rv_we; p_din = rv_din; p_req = rv_req;
      dly_cnt = dly_cfg - 1;
      log_addr.push_back(rv_addr);
      log_we.push_back(rv_we);
      log_din.push_back(rv_din);
    end
  end

  // load stream source
  logic [7:0] src_q[$];
  logic       s_pop = 1'b0;
  always @(posedge clk) if (!reset && o_s_ready && i_s_valid) s_pop = 1'b1;
  always @(negedge clk) begin
    if (s_pop && src_q.size() > 0) void'(src_q.pop_front());
    s_pop = 1'b0;
    i_s_valid = (src_q.size() > 0);
    i_s_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // save stream sink with programmable stall
  logic [7:0] sink_q[$];
  int   stall_idx = 0, stall_rem = 0, stall_seen = 0, m_err = 0, done_cnt = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (o_m_valid && sink_q.size() == stall_idx && stall_rem > 0) begin
      i_m_ready = 1'b0;
      stall_rem--;
    end else begin
      i_m_ready = 1'b1;
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (o_m_valid !== 1'b1 || o_m_data !== prev_data)) m_err++;
      if (o_m_valid && !i_m_ready) begin
        stall_seen++;
        if (rv_req !== rv_req_ack) m_err++;
      end
      if (o_m_valid && i_m_ready) sink_q.push_back(o_m_data);
      prev_stall = o_m_valid && !i_m_ready;
      prev_data  = o_m_data;
      if (o_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_lo"}, o_wram_load_ongoing, 0);
    chk({tag, "_s_ready"}, o_s_ready, 0);
    chk({tag, "_m_valid"}, o_m_valid, 0);
    chk({tag, "_m_data"}, o_m_data, 0);
    chk({tag, "_rv_req"}, rv_req, 0);
    chk({tag, "_rv_we"}, rv_we, 0);
    chk({tag, "_rv_addr"}, rv_addr, 23'h66000);
    chk({tag, "_rv_din"}, rv_din, 0);
    chk({tag, "_rv_word"}, rv_word, 0);
    chk({tag, "_rv_ds"}, rv_ds, 2'b01);
  endtask

  task automatic chk_log(input string tag, input logic we_exp, input logic [7:0] d0);
    chk({tag, "_nreq"}, log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk({tag, "_addr"}, log_addr[i], 23'h66000 + i);
      chk({tag, "_we"}, log_we[i], we_exp);
      if (we_exp) chk({tag, "_din"}, log_din[i], {8'h00, d0 + 8'(i)});
    end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_din.delete(); sink_q.delete();
    done_cnt = 0; hs_err = 0; ack_cnt = 0; m_err = 0; stall_seen = 0;
  endtask

  task automatic run_xfer(input logic dir, input int extra_at, output int lo_bad, output int cyc);
    lo_bad = 0;
    cyc = 0;
    @(negedge clk); i_dir = dir; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    while (cyc < 300) begin
      if (o_wram_load_ongoing !== dir) lo_bad++;
      if (o_done === 1'b1) break;
      @(negedge clk);
      cyc++;
      i_start = (extra_at >= 0) && (cyc == extra_at || cyc == extra_at + 3);
      i_dir = ~dir;
    end
    i_start = 1'b0;
    i_dir = dir;
  endtask

  initial begin
    int lo_bad, cyc, w;
    reset = 1'b1; i_start = 1'b0; i_dir = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // T1: load A1..A4
    clear_logs();
    src_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run_xfer(1'b1, -1, lo_bad, cyc);
    chk("t1_timeout", cyc < 300, 1);
    chk("t1_lo_during", lo_bad, 0);
    @(negedge clk);
    chk("t1_lo_after", o_wram_load_ongoing, 0);
    chk("t1_busy_after", o_busy, 0);
    repeat (3) @(negedge clk);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_hs", hs_err, 0);
    chk_log("t1", 1'b1, 8'hA1);
    chk("t1_mem3", mem[3], 8'hA4);

    // T2: save 5A..5D, 3-cycle ack delay
    clear_logs();
    dly_cfg = 3;
    mem[0] = 8'h5A; mem[1] = 8'h5B; mem[2] = 8'h5C; mem[3] = 8'h5D;
    run_xfer(1'b0, -1, lo_bad, cyc);
    chk("t2_timeout", cyc < 300, 1);
    chk("t2_lo", lo_bad, 0);
    repeat (3) @(negedge clk);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_hs", hs_err, 0);
    chk_log("t2", 1'b0, 8'h00);
    chk("t2_nbytes", sink_q.size(), 4);
    for (int i = 0; i < 4 && i < sink_q.size(); i++) chk("t2_byte", sink_q[i], 8'h5A + 8'(i));

    // T3: save with a 10-cycle stall on the second byte
    clear_logs();
    dly_cfg = 2;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    stall_idx = 1; stall_rem = 10;
    run_xfer(1'b0, -1, lo_bad, cyc);
    chk("t3_timeout", cyc < 300, 1);
    repeat (3) @(negedge clk);
    chk("t3_stall_cycles", stall_seen, 10);
    chk("t3_hold", m_err, 0);
    chk("t3_hs", hs_err, 0);
    chk("t3_nreq", log_addr.size(), 4);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_nbytes", sink_q.size(), 4);
    for (int i = 0; i < 4 && i < sink_q.size(); i++) chk("t3_byte", sink_q[i], 8'h11 * (i + 1));

    // T4: start pulses during an active load are ignored
    clear_logs();
    dly_cfg = 1;
    src_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    run_xfer(1'b1, 4, lo_bad, cyc);
    chk("t4_timeout", cyc < 300, 1);
    chk("t4_lo", lo_bad, 0);
    repeat (4) @(negedge clk);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy_after", o_busy, 0);
    chk("t4_hs", hs_err, 0);
    chk_log("t4", 1'b1, 8'hB1);

    // T5: reset after two of four load writes, then a clean load
    clear_logs();
    src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    @(negedge clk); i_dir = 1'b1; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    w = 0;
    while (ack_cnt < 2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("t5_two_writes", ack_cnt, 2);
    reset = 1'b1;
    src_q.delete();
    @(negedge clk);
    chk_reset_vals("t5_rst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_mem2_untouched", mem[2], 8'hB3);
    clear_logs();
    src_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    run_xfer(1'b1, -1, lo_bad, cyc);
    chk("t5_timeout", cyc < 300, 1);
    repeat (3) @(negedge clk);
    chk("t5_done_cnt", done_cnt, 1);
    chk_log("t5", 1'b1, 8'hD1);

`ifdef WRAM_DMA_CHECKSUM_EN
    // T6: checksum of FF,02,10,01
    clear_logs();
    src_q = '{8'hFF, 8'h02, 8'h10, 8'h01};
    run_xfer(1'b1, -1, lo_bad, cyc);
    chk("t6_timeout", cyc < 300, 1);
    chk("t6_sum_at_done", o_checksum, 8'h12);
    repeat (3) @(negedge clk);
    chk("t6_sum_hold", o_checksum, 8'h12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
